// File: rtl/matrix_pkg.sv
// matrix_pkg: shared widths, index helpers and serializer state type for the matrix multiplier blocks
package matrix_pkg;
  typedef enum logic {IDLE, STREAM} ser_state_e;
  function automatic int c_data_width(int data_w, int inner);
    return 2 * data_w + $clog2(inner);
  endfunction
  // An index into a 1-entry dimension still needs one bit to be a legal port.
  function automatic int idx_w(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int row_w(int rows);
    return idx_w(rows);
  endfunction
  function automatic int col_w(int cols);
    return idx_w(cols);
  endfunction
endpackage

// File: rtl/matrix_index_counter.sv
// matrix_index_counter: row-major 2-D index counter with enable, clear and last flag
// Ports: clk_i, reset_i (sync, active-high); clr_i returns to [0][0]; en_i advances one element;
//   row_o/col_o current index; last_o high at [ROWS-1][COLS-1].
module matrix_index_counter
  import matrix_pkg::*;
#(
  parameter int ROWS = 8,
  parameter int COLS = 5,
  localparam int RW = row_w(ROWS),
  localparam int CW = col_w(COLS)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [RW-1:0] row_o,
  output logic [CW-1:0] col_o,
  output logic          last_o
);
  logic row_end, col_end;
  assign col_end = col_o == CW'(COLS - 1);
  assign row_end = row_o == RW'(ROWS - 1);
  assign last_o  = row_end && col_end;
  always_ff @(posedge clk_i) begin
    if (reset_i || clr_i) begin
      row_o <= '0;
      col_o <= '0;
    end else if (en_i) begin
      col_o <= col_end ? '0 : col_o + 1'b1;
      row_o <= col_end ? (row_end ? '0 : row_o + 1'b1) : row_o;
    end
  end
endmodule

// File: rtl/matrix_result_serializer.sv
// matrix_result_serializer: captures the C matrix on valid_i and streams it row-major over valid/ready
// Ports: clk_i, reset_i (sync, active-high); valid_i/c_i capture strobe and matrix;
//   data_o/row_o/col_o/last_o/valid_o with ready_i form the output beat; busy_o stream active;
//   overflow_o one-cycle pulse when a capture is dropped.
// Build option MATRIX_SERIALIZER_DOUBLE_BUF_EN adds a shadow buffer holding one pending capture.
module matrix_result_serializer
  import matrix_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int A_ROWS = 8,
  parameter int B_COLUMNS = 5,
  parameter int A_COLUMNS_B_ROWS = 4,
  localparam int C_DATA_WIDTH = c_data_width(DATA_WIDTH, A_COLUMNS_B_ROWS),
  localparam int RW = row_w(A_ROWS),
  localparam int CW = col_w(B_COLUMNS)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    valid_i,
  input  logic [C_DATA_WIDTH-1:0] c_i [A_ROWS][B_COLUMNS],
  output logic [C_DATA_WIDTH-1:0] data_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [RW-1:0]           row_o,
  output logic [CW-1:0]           col_o,
  output logic                    last_o,
  output logic                    busy_o,
  output logic                    overflow_o
);
  ser_state_e state_q, state_d;
  logic [C_DATA_WIDTH-1:0] act_q [A_ROWS][B_COLUMNS];
  logic cnt_last, fin, load_c, drop;
  assign valid_o = state_q == STREAM;
  assign busy_o  = valid_o;
  assign fin     = valid_o && ready_i && cnt_last;
  assign last_o  = valid_o && cnt_last;
  // Idle output is forced to zero because the buffer itself is never reset.
  assign data_o  = valid_o ? act_q[row_o][col_o] : '0;
  matrix_index_counter #(.ROWS(A_ROWS), .COLS(B_COLUMNS)) u_idx (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .clr_i  (state_q == IDLE),
    .en_i   (valid_o && ready_i),
    .row_o  (row_o),
    .col_o  (col_o),
    .last_o (cnt_last)
  );
`ifdef MATRIX_SERIALIZER_DOUBLE_BUF_EN
  logic [C_DATA_WIDTH-1:0] shd_q [A_ROWS][B_COLUMNS];
  logic pend_q, pend_d, load_s, store_s;
  always_ff @(posedge clk_i) begin
    pend_q <= !reset_i && pend_d;
    if (store_s) shd_q <= c_i;
    if (load_c) act_q <= c_i;
    else if (load_s) act_q <= shd_q;
  end
`else
  always_ff @(posedge clk_i) begin
    if (load_c) act_q <= c_i;
  end
`endif
  always_ff @(posedge clk_i) begin
    state_q    <= reset_i ? IDLE : state_d;
    overflow_o <= !reset_i && drop;
  end
  always_comb begin
    state_d = state_q;
    load_c  = 1'b0;
    drop    = 1'b0;
`ifdef MATRIX_SERIALIZER_DOUBLE_BUF_EN
    load_s  = 1'b0;
    store_s = 1'b0;
    pend_d  = pend_q;
`endif
    if (state_q == IDLE) begin
      load_c  = valid_i;
      state_d = valid_i ? STREAM : IDLE;
    end else if (fin) begin
`ifdef MATRIX_SERIALIZER_DOUBLE_BUF_EN
      // The pending matrix is older, so it goes first and a same-cycle capture takes the shadow.
      load_s  = pend_q;
      store_s = valid_i && pend_q;
      pend_d  = valid_i && pend_q;
      load_c  = valid_i && !pend_q;
      state_d = (valid_i || pend_q) ? STREAM : IDLE;
`else
      load_c  = valid_i;
      state_d = valid_i ? STREAM : IDLE;
`endif
    end else if (valid_i) begin
`ifdef MATRIX_SERIALIZER_DOUBLE_BUF_EN
      store_s = !pend_q;
      pend_d  = 1'b1;
      drop    = pend_q;
`else
      drop    = 1'b1;
`endif
    end
  end
endmodule

// File: tb/tb_matrix_result_serializer.sv
// tb_matrix_result_serializer: scoreboard bench for the default 8x5 build and a 1x1 build
module tb_matrix_result_serializer;
  localparam int R = 8, C = 5, N = R * C, W = 18;
`ifdef MATRIX_SERIALIZER_DOUBLE_BUF_EN
  localparam int DBL = 1;
`else
  localparam int DBL = 0;
`endif
  typedef struct {
    logic [W-1:0] d;
    int           r;
    int           c;
    bit           l;
  } beat_t;

  logic clk = 0, reset_i = 1, valid_i = 0, ready_i = 1, run = 0;
  logic [W-1:0] c [R][C];
  logic [W-1:0] c1 [1][1];
  logic [W-1:0] data_o, d2_data;
  logic [2:0] row_o, col_o;
  logic d2_row, d2_col;
  logic valid_o, last_o, busy_o, ovf_o, d2_valid, d2_last, d2_busy, d2_ovf;
  beat_t q0[$], q1[$];
  int vec = 0, err = 0, eo0 = 0, eo1 = 0, so0 = 0, so1 = 0;

  always #5 clk = ~clk;
  always_comb c1[0][0] = c[0][0];

  matrix_result_serializer dut (
    .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .c_i(c), .data_o(data_o),
    .valid_o(valid_o), .ready_i(ready_i), .row_o(row_o), .col_o(col_o), .last_o(last_o),
    .busy_o(busy_o), .overflow_o(ovf_o)
  );
  matrix_result_serializer #(.A_ROWS(1), .B_COLUMNS(1)) dut1 (
    .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .c_i(c1), .data_o(d2_data),
    .valid_o(d2_valid), .ready_i(ready_i), .row_o(d2_row), .col_o(d2_col), .last_o(d2_last),
    .busy_o(d2_busy), .overflow_o(d2_ovf)
  );

  task automatic cmp(string n, logic [31:0] a, logic [31:0] e);
    vec++;
    if (a !== e) begin
      err++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  // Reference: a capture is taken whenever what is still owed after this cycle's
  // transfer fits the spare storage (nothing, or one whole matrix with the shadow).
  task automatic cycle(bit v, bit r, bit rs);
    valid_i = v;
    ready_i = r;
    reset_i = rs;
    @(posedge clk);
    if (rs) begin
      q0.delete();
      q1.delete();
    end else if (v) begin
      if (q0.size() <= DBL * N)
        for (int i = 0; i < R; i++)
          for (int j = 0; j < C; j++) q0.push_back('{c[i][j], i, j, (i == R - 1 && j == C - 1)});
      else eo0++;
      if (q1.size() <= DBL) q1.push_back('{c[0][0], 0, 0, 1'b1});
      else eo1++;
    end
    #1;
  endtask

  task automatic fill_idx();
    for (int i = 0; i < R; i++) for (int j = 0; j < C; j++) c[i][j] = W'(10 * i + j);
  endtask
  task automatic fill_const(logic [W-1:0] v);
    for (int i = 0; i < R; i++) for (int j = 0; j < C; j++) c[i][j] = v;
  endtask
  task automatic fill_rand();
    for (int i = 0; i < R; i++) for (int j = 0; j < C; j++) c[i][j] = W'($urandom);
  endtask

  always @(negedge clk) if (run) begin
    cmp("valid", valid_o, q0.size() > 0);
    cmp("busy", busy_o, q0.size() > 0);
    if (valid_o && q0.size() > 0) begin
      cmp("data", data_o, q0[0].d);
      cmp("row", row_o, q0[0].r);
      cmp("col", col_o, q0[0].c);
      cmp("last", last_o, q0[0].l);
      if (ready_i) void'(q0.pop_front());
    end else if (!valid_o) begin
      cmp("idle_out", {data_o, row_o, col_o, last_o}, 0);
    end
    if (ovf_o) so0++;
    cmp("valid_1x1", d2_valid, q1.size() > 0);
    cmp("busy_1x1", d2_busy, q1.size() > 0);
    if (d2_valid && q1.size() > 0) begin
      cmp("data_1x1", d2_data, q1[0].d);
      cmp("idx_1x1", {d2_row, d2_col, d2_last}, 3'b001);
      if (ready_i) void'(q1.pop_front());
    end else if (!d2_valid) begin
      cmp("idle_1x1", {d2_data, d2_last}, 0);
    end
    if (d2_ovf) so1++;
  end

  initial begin
    fill_idx();
    repeat (3) cycle(0, 1, 1);
    run = 1;
    cycle(0, 1, 0);
    cycle(1, 1, 0);
    repeat (45) cycle(0, 1, 0);
    cycle(1, 1, 0);
    for (int k = 1; k <= 45; k++) begin
      cycle(0, !(k >= 14 && k <= 16), 0);
      if (k == 15) cmp("stall_hold", {data_o, row_o, col_o}, {18'd23, 3'd2, 3'd3});
    end
    cycle(1, 1, 0);
    for (int k = 1; k < 40; k++) cycle(0, 1, 0);
    fill_const(18'h5A5);
    cycle(1, 1, 0);
    repeat (45) cycle(0, 1, 0);
    fill_idx();
    cycle(1, 1, 0);
    for (int k = 1; k <= 110; k++) begin
      if (k == 10) fill_const(18'h111);
      if (k == 25) fill_const(18'h222);
      cycle(k == 10 || k == 25, 1, 0);
    end
    cmp("ovf_midstream", so0, eo0);
    fill_idx();
    cycle(1, 1, 0);
    for (int k = 1; k < 20; k++) cycle(0, 1, 0);
    cycle(1, 1, 1);
    cmp("reset_abort", {valid_o, busy_o}, 2'b00);
    fill_rand();
    cycle(1, 1, 0);
    repeat (45) cycle(0, 1, 0);
    for (int k = 0; k < 3000; k++) begin
      fill_rand();
      cycle($urandom_range(19) == 0, $urandom_range(3) != 0, $urandom_range(299) == 0);
    end
    repeat (100) cycle(0, 1, 0);
    cmp("drain", q0.size(), 0);
    cmp("drain_1x1", q1.size(), 0);
    cmp("ovf_count", so0, eo0);
    cmp("ovf_count_1x1", so1, eo1);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
